// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction cache, data cache) in front
// of a single shared memory bus. One transaction is outstanding at a time.
// The data side normally wins contention. A saturating starvation counter
// hands the bus to the instruction side after STARVE_LIMIT data grants
// that were made while an instruction request was waiting.
// All outputs are registered.

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IC_REQ_SI,
  input  logic [31:0] IC_ADR_SI,
  output logic        IC_ACK_SA,
  output logic [31:0] IC_RDATA_SA,
  input  logic        DC_REQ_SM,
  input  logic [31:0] DC_ADR_SM,
  input  logic        DC_WE_SM,
  input  logic [31:0] DC_WDATA_SM,
  input  logic [3:0]  DC_BE_SM,
  output logic        DC_ACK_SA,
  output logic [31:0] DC_RDATA_SA,
  output logic        MEM_REQ_SA,
  output logic [31:0] MEM_ADR_SA,
  output logic        MEM_WE_SA,
  output logic [31:0] MEM_WDATA_SA,
  output logic [3:0]  MEM_BE_SA,
  input  logic        MEM_ACK_SX,
  input  logic [31:0] MEM_RDATA_SX
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // FSM encoding; value 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CNT_W-1:0] starve_cnt;

  logic i_elig_s;
  logic d_elig_s;
  logic starved_s;
  logic grant_i_s;
  logic grant_d_s;
  logic busy_s;
  logic state_legal_s;
  logic done_i_s;
  logic done_d_s;

  // Eligibility: only in IDLE, and a side still showing its ACK is masked so
  // a requester that holds REQ into its ACK cycle cannot be re-granted.
  always_comb begin
    i_elig_s = 1'b0;
    d_elig_s = 1'b0;
    if (state_r == IDLE) begin
      i_elig_s = IC_REQ_SI & ~IC_ACK_SA;
      d_elig_s = DC_REQ_SM & ~DC_ACK_SA;
    end else begin
      i_elig_s = 1'b0;
      d_elig_s = 1'b0;
    end
  end

  // Grant decision: data side first unless the instruction side has waited
  // through STARVE_LIMIT data grants.
  always_comb begin
    starved_s = (starve_cnt == STARVE_MAX);
    grant_d_s = d_elig_s & (~i_elig_s | ~starved_s);
    grant_i_s = i_elig_s & ~grant_d_s;
  end

  // Completion decode: a bus ack only counts while a transaction is open.
  always_comb begin
    busy_s        = (state_r == BUSY_I) || (state_r == BUSY_D);
    state_legal_s = (state_r == IDLE) || busy_s;
    done_i_s      = (state_r == BUSY_I) & MEM_ACK_SX;
    done_d_s      = (state_r == BUSY_D) & MEM_ACK_SX;
  end

  // Next-state logic for the IDLE / BUSY_I / BUSY_D sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          next_state_s = BUSY_D;
        end else if (grant_i_s) begin
          next_state_s = BUSY_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (MEM_ACK_SX) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Starvation counter: counts data grants made while the instruction side
  // is requesting, saturates at the limit, clears otherwise on any grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt <= CNT_ZERO;
    end else if (grant_d_s) begin
      if (!IC_REQ_SI) begin
        starve_cnt <= CNT_ZERO;
      end else if (starved_s) begin
        starve_cnt <= starve_cnt;
      end else begin
        starve_cnt <= starve_cnt + CNT_ONE;
      end
    end else if (grant_i_s) begin
      starve_cnt <= CNT_ZERO;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Bus request and payload: captured at grant, frozen for the whole busy
  // period, request dropped on completion. The payload keeps its last value
  // between transactions.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      MEM_REQ_SA   <= 1'b0;
      MEM_ADR_SA   <= 32'h0000_0000;
      MEM_WE_SA    <= 1'b0;
      MEM_WDATA_SA <= 32'h0000_0000;
      MEM_BE_SA    <= 4'h0;
    end else if (grant_d_s) begin
      MEM_REQ_SA   <= 1'b1;
      MEM_ADR_SA   <= DC_ADR_SM;
      MEM_WE_SA    <= DC_WE_SM;
      MEM_WDATA_SA <= DC_WDATA_SM;
      MEM_BE_SA    <= DC_BE_SM;
    end else if (grant_i_s) begin
      // Instruction fetches are always full-word reads.
      MEM_REQ_SA   <= 1'b1;
      MEM_ADR_SA   <= IC_ADR_SI;
      MEM_WE_SA    <= 1'b0;
      MEM_WDATA_SA <= 32'h0000_0000;
      MEM_BE_SA    <= 4'hF;
    end else if (done_i_s || done_d_s || !state_legal_s) begin
      MEM_REQ_SA   <= 1'b0;
    end else begin
      MEM_REQ_SA   <= MEM_REQ_SA;
    end
  end

  // Instruction-side completion: one-cycle ack pulse, read data held until
  // the next instruction-side completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      IC_ACK_SA   <= 1'b0;
      IC_RDATA_SA <= 32'h0000_0000;
    end else begin
      IC_ACK_SA <= done_i_s;
      if (done_i_s) begin
        IC_RDATA_SA <= MEM_RDATA_SX;
      end else begin
        IC_RDATA_SA <= IC_RDATA_SA;
      end
    end
  end

  // Data-side completion: one-cycle ack pulse, read data held until the next
  // data-side completion (meaningless after a store).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      DC_ACK_SA   <= 1'b0;
      DC_RDATA_SA <= 32'h0000_0000;
    end else begin
      DC_ACK_SA <= done_d_s;
      if (done_d_s) begin
        DC_RDATA_SA <= MEM_RDATA_SX;
      end else begin
        DC_RDATA_SA <= DC_RDATA_SA;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run, all checked every cycle against a transaction-level reference model.

module tb_mem_arbiter;

  localparam int STARVE   = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IC_REQ_SI;
  logic [31:0] IC_ADR_SI;
  logic        IC_ACK_SA;
  logic [31:0] IC_RDATA_SA;
  logic        DC_REQ_SM;
  logic [31:0] DC_ADR_SM;
  logic        DC_WE_SM;
  logic [31:0] DC_WDATA_SM;
  logic [3:0]  DC_BE_SM;
  logic        DC_ACK_SA;
  logic [31:0] DC_RDATA_SA;
  logic        MEM_REQ_SA;
  logic [31:0] MEM_ADR_SA;
  logic        MEM_WE_SA;
  logic [31:0] MEM_WDATA_SA;
  logic [3:0]  MEM_BE_SA;
  logic        MEM_ACK_SX;
  logic [31:0] MEM_RDATA_SX;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset_n(reset_n),
    .IC_REQ_SI(IC_REQ_SI), .IC_ADR_SI(IC_ADR_SI),
    .IC_ACK_SA(IC_ACK_SA), .IC_RDATA_SA(IC_RDATA_SA),
    .DC_REQ_SM(DC_REQ_SM), .DC_ADR_SM(DC_ADR_SM), .DC_WE_SM(DC_WE_SM),
    .DC_WDATA_SM(DC_WDATA_SM), .DC_BE_SM(DC_BE_SM),
    .DC_ACK_SA(DC_ACK_SA), .DC_RDATA_SA(DC_RDATA_SA),
    .MEM_REQ_SA(MEM_REQ_SA), .MEM_ADR_SA(MEM_ADR_SA), .MEM_WE_SA(MEM_WE_SA),
    .MEM_WDATA_SA(MEM_WDATA_SA), .MEM_BE_SA(MEM_BE_SA),
    .MEM_ACK_SX(MEM_ACK_SX), .MEM_RDATA_SX(MEM_RDATA_SX)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, what the bus carries, what each side
  // last received, and how long the instruction side has been passed over.
  int          m_owner    = OWN_NONE;
  int          m_starve   = 0;
  logic        m_ic_ack   = 1'b0;
  logic        m_dc_ack   = 1'b0;
  logic        m_mem_req  = 1'b0;
  logic        m_we       = 1'b0;
  logic [3:0]  m_be       = 4'h0;
  logic [31:0] m_adr      = 32'h0;
  logic [31:0] m_wdata    = 32'h0;
  logic [31:0] m_ic_rdata = 32'h0;
  logic [31:0] m_dc_rdata = 32'h0;

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    m_ic_ack <= 1'b0;
    m_dc_ack <= 1'b0;
    if (!reset_n) begin
      m_owner <= OWN_NONE; m_starve <= 0; m_mem_req <= 1'b0; m_we <= 1'b0;
      m_be <= 4'h0; m_adr <= 32'h0; m_wdata <= 32'h0;
      m_ic_rdata <= 32'h0; m_dc_rdata <= 32'h0;
    end else if (m_owner == OWN_NONE) begin
      if (DC_REQ_SM && !m_dc_ack && (!(IC_REQ_SI && !m_ic_ack) || m_starve < STARVE)) begin
        m_owner <= OWN_D; m_mem_req <= 1'b1;
        m_adr <= DC_ADR_SM; m_we <= DC_WE_SM; m_wdata <= DC_WDATA_SM; m_be <= DC_BE_SM;
        m_starve <= IC_REQ_SI ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
      end else if (IC_REQ_SI && !m_ic_ack) begin
        m_owner <= OWN_I; m_mem_req <= 1'b1;
        m_adr <= IC_ADR_SI; m_we <= 1'b0; m_wdata <= 32'h0; m_be <= 4'hF;
        m_starve <= 0;
      end
    end else if (MEM_ACK_SX) begin
      if (m_owner == OWN_I) begin
        m_ic_ack <= 1'b1; m_ic_rdata <= MEM_RDATA_SX;
      end else begin
        m_dc_ack <= 1'b1; m_dc_rdata <= MEM_RDATA_SX;
      end
      m_owner <= OWN_NONE; m_mem_req <= 1'b0;
    end
  end

  // Bench knobs: memory responder and requester handshake behaviour.
  bit          auto_mem  = 1'b0;
  int          mem_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] mem_val   = 32'h0;
  bit          hs_on     = 1'b0;
  bit          late      = 1'b0;
  bit          ic_drop   = 1'b0;
  bit          dc_drop   = 1'b0;
  int          cyc       = 0;
  logic        prev_req  = 1'b0;

  // Observation logs.
  logic [31:0] g_adr[$];
  logic [31:0] g_wdata[$];
  logic [3:0]  g_be[$];
  logic        g_we[$];
  int          g_cyc[$];
  int          a_side[$];
  int          a_cyc[$];

  task automatic clear_logs();
    g_adr.delete(); g_wdata.delete(); g_be.delete(); g_we.delete();
    g_cyc.delete(); a_side.delete(); a_cyc.delete();
  endtask

  // One clock cycle: compare against the model, log events, then run the
  // memory responder and the requester handshake.
  task automatic tick();
    @(negedge clk);
    cyc++;
    n_tests++;
    if ({IC_ACK_SA, DC_ACK_SA, MEM_REQ_SA, MEM_WE_SA, MEM_BE_SA, MEM_ADR_SA,
         MEM_WDATA_SA, IC_RDATA_SA, DC_RDATA_SA} !==
        {m_ic_ack, m_dc_ack, m_mem_req, m_we, m_be, m_adr, m_wdata, m_ic_rdata, m_dc_rdata}) begin
      n_fail++;
      $display("FAIL model_cycle %0d: got ack_i=%b ack_d=%b req=%b we=%b be=%h adr=%h wd=%h ird=%h drd=%h required ack_i=%b ack_d=%b req=%b we=%b be=%h adr=%h wd=%h ird=%h drd=%h",
               cyc, IC_ACK_SA, DC_ACK_SA, MEM_REQ_SA, MEM_WE_SA, MEM_BE_SA, MEM_ADR_SA,
               MEM_WDATA_SA, IC_RDATA_SA, DC_RDATA_SA, m_ic_ack, m_dc_ack, m_mem_req,
               m_we, m_be, m_adr, m_wdata, m_ic_rdata, m_dc_rdata);
    end
    n_tests++;
    if (int'(dut.starve_cnt) != m_starve) begin
      n_fail++;
      $display("FAIL model_starve %0d: got %0d required %0d", cyc, dut.starve_cnt, m_starve);
    end
    n_tests++;
    if (IC_ACK_SA === 1'b1 && DC_ACK_SA === 1'b1) begin
      n_fail++;
      $display("FAIL ack_exclusive %0d: got both acks high required at most one", cyc);
    end
    if (IC_ACK_SA === 1'b1) begin a_side.push_back(OWN_I); a_cyc.push_back(cyc); end
    if (DC_ACK_SA === 1'b1) begin a_side.push_back(OWN_D); a_cyc.push_back(cyc); end
    if (MEM_REQ_SA === 1'b1 && prev_req !== 1'b1) begin
      g_adr.push_back(MEM_ADR_SA); g_wdata.push_back(MEM_WDATA_SA);
      g_be.push_back(MEM_BE_SA); g_we.push_back(MEM_WE_SA); g_cyc.push_back(cyc);
    end
    prev_req = MEM_REQ_SA;
    if (auto_mem) begin
      if (m_mem_req && wait_cnt >= mem_delay) begin
        MEM_ACK_SX = 1'b1; MEM_RDATA_SX = mem_val; wait_cnt = 0;
      end else if (m_mem_req) begin
        MEM_ACK_SX = 1'b0; wait_cnt++;
      end else begin
        MEM_ACK_SX = 1'b0; wait_cnt = 0;
      end
    end
    if (hs_on) begin
      if (ic_drop) begin IC_REQ_SI = 1'b0; ic_drop = 1'b0; end
      if (dc_drop) begin DC_REQ_SM = 1'b0; dc_drop = 1'b0; end
      if (IC_ACK_SA === 1'b1) begin if (late) ic_drop = 1'b1; else IC_REQ_SI = 1'b0; end
      if (DC_ACK_SA === 1'b1) begin if (late) dc_drop = 1'b1; else DC_REQ_SM = 1'b0; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; IC_REQ_SI = 1'b0; IC_ADR_SI = 32'h0; DC_REQ_SM = 1'b0;
    DC_ADR_SM = 32'h0; DC_WE_SM = 1'b0; DC_WDATA_SM = 32'h0; DC_BE_SM = 4'h0;
    MEM_ACK_SX = 1'b0; MEM_RDATA_SX = 32'h0;
    tick(); tick();
    n_tests++;
    if ({IC_ACK_SA, DC_ACK_SA, MEM_REQ_SA, MEM_WE_SA, MEM_BE_SA, MEM_ADR_SA,
         MEM_WDATA_SA, IC_RDATA_SA, DC_RDATA_SA} !== 136'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b we=%b adr=%h required all zero", MEM_REQ_SA, MEM_WE_SA, MEM_ADR_SA);
    end
    n_tests++;
    if (int'(dut.starve_cnt) != 0) begin
      n_fail++; $display("FAIL reset_starve: got %0d required 0", dut.starve_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_i();
    int req_at = -1;
    int ack_at = -1;
    int start;
    auto_mem = 1'b1; mem_delay = 3; mem_val = 32'hDEAD_BEEF; hs_on = 1'b1; late = 1'b0;
    clear_logs();
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h0000_0100;
    start = cyc;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (MEM_REQ_SA === 1'b1) begin
        if (req_at < 0) req_at = cyc - start;
        n_tests++;
        if (MEM_ADR_SA !== 32'h100 || MEM_WE_SA !== 1'b0 || MEM_BE_SA !== 4'hF) begin
          n_fail++;
          $display("FAIL single_i_bus: got adr=%h we=%b be=%h required adr=00000100 we=0 be=f", MEM_ADR_SA, MEM_WE_SA, MEM_BE_SA);
        end
      end
      if (IC_ACK_SA === 1'b1 && ack_at < 0) ack_at = cyc - start;
    end
    n_tests++;
    if (req_at != 1 || ack_at != 5) begin
      n_fail++; $display("FAIL single_i_latency: got req@%0d ack@%0d required req@1 ack@5", req_at, ack_at);
    end
    n_tests++;
    if (a_side.size() != 1 || IC_RDATA_SA !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_i_ack: got %0d acks rdata=%h required 1 ack rdata=deadbeef", a_side.size(), IC_RDATA_SA);
    end
  endtask

  task automatic test_min_latency();
    auto_mem = 1'b1; mem_delay = 0; mem_val = 32'h1234_5678; hs_on = 1'b1;
    DC_REQ_SM = 1'b1; DC_ADR_SM = 32'h40; DC_WE_SM = 1'b0; DC_WDATA_SM = 32'h0; DC_BE_SM = 4'b1100;
    tick();
    n_tests++;
    if (MEM_REQ_SA !== 1'b1 || MEM_ADR_SA !== 32'h40 || MEM_BE_SA !== 4'b1100 || MEM_WE_SA !== 1'b0) begin
      n_fail++; $display("FAIL min_lat_req: got req=%b adr=%h be=%b required req=1 adr=00000040 be=1100", MEM_REQ_SA, MEM_ADR_SA, MEM_BE_SA);
    end
    tick();
    n_tests++;
    if (DC_ACK_SA !== 1'b1 || DC_RDATA_SA !== 32'h1234_5678 || IC_RDATA_SA !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL min_lat_ack: got ack=%b drd=%h ird=%h required ack=1 drd=12345678 ird=deadbeef", DC_ACK_SA, DC_RDATA_SA, IC_RDATA_SA);
    end
    tick();
    n_tests++;
    if (DC_ACK_SA !== 1'b0 || MEM_REQ_SA !== 1'b0) begin
      n_fail++; $display("FAIL min_lat_pulse: got ack=%b req=%b required 0 0", DC_ACK_SA, MEM_REQ_SA);
    end
  endtask

  task automatic test_simultaneous();
    auto_mem = 1'b1; mem_delay = int'($urandom_range(2, 0)); mem_val = $urandom; hs_on = 1'b1;
    clear_logs();
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h300;
    DC_REQ_SM = 1'b1; DC_ADR_SM = 32'h2000; DC_WE_SM = 1'b1; DC_WDATA_SM = 32'h55; DC_BE_SM = 4'b0001;
    for (int i = 0; i < 40 && a_side.size() < 2; i++) tick();
    tick(); tick();
    n_tests++;
    if (a_side.size() != 2 || g_adr.size() != 2) begin
      n_fail++; $display("FAIL simul_count: got %0d acks %0d grants required 2 2", a_side.size(), g_adr.size());
    end else begin
      n_tests++;
      if (a_side[0] != OWN_D || a_side[1] != OWN_I) begin
        n_fail++; $display("FAIL simul_order: got %0d,%0d required D(2) then I(1)", a_side[0], a_side[1]);
      end
      n_tests++;
      if (g_adr[0] !== 32'h2000 || g_we[0] !== 1'b1 || g_be[0] !== 4'b0001 || g_wdata[0] !== 32'h55) begin
        n_fail++; $display("FAIL simul_d_bus: got adr=%h we=%b be=%b wd=%h required 00002000 1 0001 00000055", g_adr[0], g_we[0], g_be[0], g_wdata[0]);
      end
      n_tests++;
      if (g_adr[1] !== 32'h300 || g_we[1] !== 1'b0 || g_be[1] !== 4'hF || g_wdata[1] !== 32'h0) begin
        n_fail++; $display("FAIL simul_i_bus: got adr=%h we=%b be=%h wd=%h required 00000300 0 f 0", g_adr[1], g_we[1], g_be[1], g_wdata[1]);
      end
      n_tests++;
      if (g_cyc[1] != a_cyc[0] + 1) begin
        n_fail++; $display("FAIL simul_gap: got i grant at %0d required %0d", g_cyc[1], a_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_adr;
    int exp_cnt;
    auto_mem = 1'b1; mem_delay = 0; hs_on = 1'b0;
    IC_ADR_SI = 32'h500; DC_WE_SM = 1'b0; DC_BE_SM = 4'hF;
    for (int k = 0; k < 6; k++) begin
      IC_REQ_SI = 1'b1; DC_REQ_SM = 1'b1; DC_ADR_SM = 32'h4000 + 32'(k * 4);
      exp_adr = (k == 4) ? 32'h500 : 32'h4000 + 32'(k * 4);
      exp_cnt = (k < 4) ? k + 1 : ((k == 4) ? 0 : 1);
      tick();
      n_tests++;
      if (MEM_REQ_SA !== 1'b1 || MEM_ADR_SA !== exp_adr) begin
        n_fail++; $display("FAIL starve_grant_%0d: got req=%b adr=%h required req=1 adr=%h", k, MEM_REQ_SA, MEM_ADR_SA, exp_adr);
      end
      n_tests++;
      if (int'(dut.starve_cnt) != exp_cnt) begin
        n_fail++; $display("FAIL starve_cnt_%0d: got %0d required %0d", k, dut.starve_cnt, exp_cnt);
      end
      IC_REQ_SI = 1'b0; DC_REQ_SM = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic test_reset_mid();
    auto_mem = 1'b0; hs_on = 1'b0; MEM_ACK_SX = 1'b0;
    DC_REQ_SM = 1'b1; DC_ADR_SM = 32'h6000; DC_WE_SM = 1'b1; DC_WDATA_SM = 32'hA5A5; DC_BE_SM = 4'b0011;
    tick(); tick();
    n_tests++;
    if (MEM_REQ_SA !== 1'b1) begin
      n_fail++; $display("FAIL rmid_busy: got req=%b required 1", MEM_REQ_SA);
    end
    reset_n = 1'b0;
    tick();
    n_tests++;
    if (MEM_REQ_SA !== 1'b0 || DC_ACK_SA !== 1'b0 || MEM_ADR_SA !== 32'h0 || MEM_WE_SA !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort: got req=%b ack=%b adr=%h required 0 0 0", MEM_REQ_SA, DC_ACK_SA, MEM_ADR_SA);
    end
    reset_n = 1'b1; DC_REQ_SM = 1'b0; MEM_ACK_SX = 1'b1; MEM_RDATA_SX = 32'hBAD0_BAD0;
    tick();
    MEM_ACK_SX = 1'b0;
    tick();
    n_tests++;
    if (DC_ACK_SA !== 1'b0 || MEM_REQ_SA !== 1'b0 || DC_RDATA_SA !== 32'h0) begin
      n_fail++; $display("FAIL rmid_late_ack: got ack=%b req=%b drd=%h required 0 0 0", DC_ACK_SA, MEM_REQ_SA, DC_RDATA_SA);
    end
    auto_mem = 1'b1; mem_delay = 0; mem_val = 32'h7777_0000; hs_on = 1'b1;
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h700;
    tick();
    n_tests++;
    if (MEM_REQ_SA !== 1'b1 || MEM_ADR_SA !== 32'h700) begin
      n_fail++; $display("FAIL rmid_idle: got req=%b adr=%h required 1 00000700", MEM_REQ_SA, MEM_ADR_SA);
    end
    tick(); tick();
  endtask

  task automatic test_stray();
    auto_mem = 1'b0; hs_on = 1'b0;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      MEM_ACK_SX = 1'b1; MEM_RDATA_SX = $urandom;
      tick();
    end
    MEM_ACK_SX = 1'b0;
    tick();
    n_tests++;
    if (g_adr.size() != 0 || a_side.size() != 0 || IC_RDATA_SA !== 32'h7777_0000) begin
      n_fail++; $display("FAIL stray_ack: got %0d grants %0d acks ird=%h required 0 0 77770000", g_adr.size(), a_side.size(), IC_RDATA_SA);
    end
    auto_mem = 1'b1; mem_delay = 1; mem_val = 32'hCAFE_F00D; hs_on = 1'b1; late = 1'b1;
    IC_REQ_SI = 1'b1; IC_ADR_SI = 32'h800;
    for (int i = 0; i < 12; i++) tick();
    late = 1'b0;
    n_tests++;
    if (g_adr.size() != 1 || a_side.size() != 1) begin
      n_fail++; $display("FAIL late_req_dup: got %0d grants %0d acks required 1 1", g_adr.size(), a_side.size());
    end
  endtask

  task automatic test_random();
    auto_mem = 1'b0; hs_on = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      reset_n      = ($urandom_range(199, 0) != 0);
      IC_REQ_SI    = ($urandom_range(9, 0) < 6);
      DC_REQ_SM    = ($urandom_range(9, 0) < 7);
      IC_ADR_SI    = $urandom;
      DC_ADR_SM    = $urandom;
      DC_WE_SM     = 1'($urandom);
      DC_WDATA_SM  = $urandom;
      DC_BE_SM     = 4'($urandom);
      MEM_ACK_SX   = ($urandom_range(2, 0) == 0);
      MEM_RDATA_SX = $urandom;
    end
    reset_n = 1'b1; IC_REQ_SI = 1'b0; DC_REQ_SM = 1'b0; MEM_ACK_SX = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_min_latency();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_stray();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-side grants while an instruction request waits.
REQ-002 Ports SHALL be, one per line, in this order:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- IC_REQ_SI  in  1  instruction-cache miss request.
- IC_ADR_SI  in  32  instruction miss address.
- IC_ACK_SA  out  1  instruction transfer done; one-cycle pulse.
- IC_RDATA_SA  out  32  instruction read data; valid with IC_ACK_SA.
- DC_REQ_SM  in  1  data-cache request.
- DC_ADR_SM  in  32  data address.
- DC_WE_SM  in  1  1 = store, 0 = load.
- DC_WDATA_SM  in  32  store data.
- DC_BE_SM  in  4  byte enables.
- DC_ACK_SA  out  1  data transfer done; one-cycle pulse.
- DC_RDATA_SA  out  32  load data; valid with DC_ACK_SA.
- MEM_REQ_SA  out  1  shared bus request.
- MEM_ADR_SA  out  32  bus address.
- MEM_WE_SA  out  1  bus write.
- MEM_WDATA_SA  out  32  bus write data.
- MEM_BE_SA  out  4  bus byte enables.
- MEM_ACK_SX  in  1  bus completion.
- MEM_RDATA_SX  in  32  bus read data; valid with MEM_ACK_SX.

Function
REQ-003 FSM states SHALL be IDLE, BUSY_I and BUSY_D; exactly one transaction is outstanding at a time.
REQ-004 Handshake: a requester holds REQ and its payload stable until it sees its ACK, then drops REQ in the ACK cycle.
REQ-005 In IDLE, a requester SHALL be eligible only if its REQ is 1 and its ACK output is 0 in that cycle.
REQ-006 In IDLE with only one eligible requester, the FSM SHALL go to that requester's BUSY state at the next edge.
REQ-007 In IDLE with both eligible, D SHALL win unless starve_cnt == STARVE_LIMIT, in which case I SHALL win.
REQ-008 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on a D grant while IC_REQ_SI=1, saturate at STARVE_LIMIT, and clear on any I grant or any D grant with IC_REQ_SI=0.
REQ-009 On entry to BUSY_x, MEM_ADR/WE/WDATA/BE SHALL be registered from requester x and MEM_REQ_SA driven to 1.
- I side always uses WE=0, BE=4'hF, WDATA=0.
REQ-010 MEM_* outputs SHALL remain constant for the whole BUSY state.
REQ-011 On a cycle in BUSY_x with MEM_ACK_SX=1, at the next edge the block SHALL:
- clear MEM_REQ_SA;
- register MEM_RDATA_SX into x_RDATA_SA;
- pulse x_ACK_SA for exactly one cycle;
- return to IDLE.
REQ-012 Minimum per-transaction latency SHALL be: REQ sampled at t -> MEM_REQ_SA at t+1 -> ack at t+1 -> x_ACK_SA at t+2.
- Back-to-back grants are separated by at least one IDLE cycle.
REQ-013 x_RDATA_SA SHALL hold its value until the next ACK on that side.
- For stores, DC_RDATA_SA is updated but is don't-care.
REQ-014 MEM_ACK_SX while in IDLE SHALL be ignored.
REQ-015 A requester dropping REQ during its own BUSY state SHALL NOT abort the transaction: completion and ACK still occur.
REQ-016 IC_ACK_SA and DC_ACK_SA SHALL never be 1 in the same cycle.

Reset
REQ-017 With reset_n=0 at a rising edge, the block SHALL:
- set state to IDLE and starve_cnt to 0;
- clear MEM_REQ_SA, MEM_WE_SA, IC_ACK_SA and DC_ACK_SA;
- clear all address, data and BE registers to 0.
REQ-018 Reset during BUSY SHALL abandon the transaction: no ACK is issued, and a MEM_ACK_SX arriving after reset is ignored per REQ-014.

Verification
REQ-019 Single I miss:
- Stimulus: IC_REQ=1, ADR=0x100; memory acks after 3 cycles with 0xDEADBEEF.
- Response: MEM_ADR=0x100, WE=0 throughout; one IC_ACK pulse; IC_RDATA=0xDEADBEEF.
REQ-020 Simultaneous requests:
- Stimulus: IC_REQ and DC_REQ (store 0x55 to 0x2000, BE=4'b0001) rise in the same cycle.
- Response: D is served first with MEM_WE=1 and BE=0001; I is served after one IDLE cycle.
REQ-021 Starvation:
- Stimulus: DC_REQ reasserted continuously while IC_REQ is held, STARVE_LIMIT=4.
- Response: exactly 4 D grants, then an I grant, then starve_cnt=0.
REQ-022 Reset mid-transaction:
- Stimulus: reset_n=0 for one cycle during BUSY_D, then a late MEM_ACK.
- Response: MEM_REQ=0 the next cycle, no DC_ACK pulse, FSM in IDLE.
REQ-023 Stray and late inputs:
- Stimulus: MEM_ACK pulsed in IDLE; REQ held one cycle past ACK.
- Response: no bus activity, and no duplicate grant.
